// File: rtl/bev_dram_responder.sv
// AXI4-Lite slave modelling the 256 x 64-bit Data_Dir DRAM of the beverage program block.
// Serves one single-beat read or write at a time with parameterised response latency.
module bev_dram_responder #(
   parameter logic [16:0] BASE_ADDR = 17'h10000,
   parameter int          RD_LAT    = 2,
   parameter int          WR_LAT    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        AR_VALID,
   input  logic [16:0] AR_ADDR,
   output logic        AR_READY,
   output logic        R_VALID,
   output logic [63:0] R_DATA,
   output logic [1:0]  R_RESP,
   input  logic        R_READY,
   input  logic        AW_VALID,
   input  logic [16:0] AW_ADDR,
   output logic        AW_READY,
   input  logic        W_VALID,
   input  logic [63:0] W_DATA,
   output logic        W_READY,
   output logic        B_VALID,
   output logic [1:0]  B_RESP,
   input  logic        B_READY
);

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] RD_WAIT    = 3'd1;
   localparam logic [2:0] RD_RESP    = 3'd2;
   localparam logic [2:0] WR_COLLECT = 3'd3;
   localparam logic [2:0] WR_WAIT    = 3'd4;
   localparam logic [2:0] WR_RESP    = 3'd5;

   localparam logic [3:0] RD_WAIT_CYC = 4'(RD_LAT - 1);
   localparam logic [3:0] WR_WAIT_CYC = 4'(WR_LAT - 1);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [2:0]  state;
   logic [3:0]  cnt;
   logic [16:0] rd_addr_q;
   logic [16:0] wr_addr_q;
   logic [63:0] wr_data_q;
   logic        aw_got;
   logic        w_got;
   logic [63:0] mem [0:255];

   logic        ar_hs;
   logic        aw_hs;
   logic        w_hs;
   logic        wr_complete;
   logic        rd_launch;
   logic        commit_now;
   logic        mem_we;
   logic        rd_ok;
   logic        wr_ok;
   logic [16:0] rd_addr_eff;
   logic [16:0] wr_addr_eff;
   logic [63:0] wr_data_eff;

   function automatic logic addr_ok(input logic [16:0] a);
      return (a[2:0] == 3'b000) &&
             ({1'b0, a} >= {1'b0, BASE_ADDR}) &&
             ({1'b0, a} <= ({1'b0, BASE_ADDR} + 18'h007F8));
   endfunction

   function automatic logic [7:0] addr_idx(input logic [16:0] a);
      return 8'((a - BASE_ADDR) >> 3);
   endfunction

   always_comb begin
      AR_READY = 1'b0;
      AW_READY = 1'b0;
      W_READY  = 1'b0;
      case (state)
         IDLE: begin
            // A pending read always beats a simultaneous write request
            AR_READY = 1'b1;
            AW_READY = !AR_VALID;
            W_READY  = !AR_VALID;
         end
         WR_COLLECT: begin
            AW_READY = !aw_got;
            W_READY  = !w_got;
         end
         default: ;
      endcase
   end

   assign ar_hs = AR_VALID && AR_READY;
   assign aw_hs = AW_VALID && AW_READY;
   assign w_hs  = W_VALID && W_READY;

   assign wr_complete = ((state == IDLE) || (state == WR_COLLECT)) &&
                        (aw_got || aw_hs) && (w_got || w_hs);

   // With a latency of one the response is produced straight from the handshake cycle
   assign rd_addr_eff = ar_hs ? AR_ADDR : rd_addr_q;
   assign wr_addr_eff = aw_hs ? AW_ADDR : wr_addr_q;
   assign wr_data_eff = w_hs ? W_DATA : wr_data_q;

   assign rd_launch  = (ar_hs && (RD_LAT == 1)) || ((state == RD_WAIT) && (cnt == 4'd1));
   assign commit_now = (wr_complete && (WR_LAT == 1)) || ((state == WR_WAIT) && (cnt == 4'd1));
   assign rd_ok      = addr_ok(rd_addr_eff);
   assign wr_ok      = addr_ok(wr_addr_eff);
   assign mem_we     = rst_n && commit_now && wr_ok;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[addr_idx(wr_addr_eff)] <= wr_data_eff;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         aw_got    <= 1'b0;
         w_got     <= 1'b0;
         R_VALID   <= 1'b0;
         R_DATA    <= '0;
         R_RESP    <= RESP_OKAY;
         B_VALID   <= 1'b0;
         B_RESP    <= RESP_OKAY;
      end else begin
         case (state)
            IDLE: begin
               if (ar_hs) begin
                  rd_addr_q <= AR_ADDR;
                  if (RD_LAT == 1) begin
                     state <= RD_RESP;
                  end else begin
                     state <= RD_WAIT;
                     cnt   <= RD_WAIT_CYC;
                  end
               end else if (aw_hs || w_hs) begin
                  if (aw_hs) wr_addr_q <= AW_ADDR;
                  if (w_hs)  wr_data_q <= W_DATA;
                  if (wr_complete) begin
                     state <= (WR_LAT == 1) ? WR_RESP : WR_WAIT;
                     cnt   <= WR_WAIT_CYC;
                  end else begin
                     state  <= WR_COLLECT;
                     aw_got <= aw_hs;
                     w_got  <= w_hs;
                  end
               end
            end
            RD_WAIT: begin
               if (cnt == 4'd1) begin
                  state <= RD_RESP;
                  cnt   <= 4'd0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RD_RESP: begin
               if (R_READY) begin
                  state   <= IDLE;
                  R_VALID <= 1'b0;
                  R_DATA  <= '0;
                  R_RESP  <= RESP_OKAY;
               end
            end
            WR_COLLECT: begin
               if (aw_hs) wr_addr_q <= AW_ADDR;
               if (w_hs)  wr_data_q <= W_DATA;
               if (wr_complete) begin
                  state  <= (WR_LAT == 1) ? WR_RESP : WR_WAIT;
                  cnt    <= WR_WAIT_CYC;
                  aw_got <= 1'b0;
                  w_got  <= 1'b0;
               end
            end
            WR_WAIT: begin
               if (cnt == 4'd1) begin
                  state <= WR_RESP;
                  cnt   <= 4'd0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            WR_RESP: begin
               if (B_READY) begin
                  state   <= IDLE;
                  B_VALID <= 1'b0;
                  B_RESP  <= RESP_OKAY;
               end
            end
            default: state <= IDLE;
         endcase

         if (rd_launch) begin
            R_VALID <= 1'b1;
            R_DATA  <= rd_ok ? mem[addr_idx(rd_addr_eff)] : '0;
            R_RESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
         end

         if (commit_now) begin
            B_VALID <= 1'b1;
            B_RESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

endmodule

// File: tb/tb_bev_dram_responder.sv
// Bench for bev_dram_responder: directed transactions plus random traffic checked
// against a flat array model of the record store and its address rules.
module tb_bev_dram_responder;

   localparam int RD_LAT = 2;
   localparam int WR_LAT = 2;
   localparam int BASE   = 'h10000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        AR_VALID = 1'b0;
   logic [16:0] AR_ADDR = '0;
   logic        AR_READY;
   logic        R_VALID;
   logic [63:0] R_DATA;
   logic [1:0]  R_RESP;
   logic        R_READY = 1'b0;
   logic        AW_VALID = 1'b0;
   logic [16:0] AW_ADDR = '0;
   logic        AW_READY;
   logic        W_VALID = 1'b0;
   logic [63:0] W_DATA = '0;
   logic        W_READY;
   logic        B_VALID;
   logic [1:0]  B_RESP;
   logic        B_READY = 1'b0;

   int total = 0;
   int bad   = 0;
   logic [63:0] model_mem [256];

   bev_dram_responder #(
      .BASE_ADDR(17'h10000),
      .RD_LAT   (RD_LAT),
      .WR_LAT   (WR_LAT)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .AR_VALID(AR_VALID),
      .AR_ADDR (AR_ADDR),
      .AR_READY(AR_READY),
      .R_VALID (R_VALID),
      .R_DATA  (R_DATA),
      .R_RESP  (R_RESP),
      .R_READY (R_READY),
      .AW_VALID(AW_VALID),
      .AW_ADDR (AW_ADDR),
      .AW_READY(AW_READY),
      .W_VALID (W_VALID),
      .W_DATA  (W_DATA),
      .W_READY (W_READY),
      .B_VALID (B_VALID),
      .B_RESP  (B_RESP),
      .B_READY (B_READY)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic bit ref_ok(input int a);
      return (a % 8 == 0) && (a >= BASE) && (a <= BASE + 255 * 8);
   endfunction

   function automatic int ref_idx(input int a);
      return (a - BASE) / 8;
   endfunction

   task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic finish_write(input int addr);
      int cyc;
      cyc = 1;
      while (B_VALID !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_output("b_latency", 64'(cyc), 64'(WR_LAT));
      check_output("b_resp", B_RESP, ref_ok(addr) ? 64'd0 : 64'd2);
      @(posedge clk); #1;
      check_output("b_valid_clear", B_VALID, 0);
      check_output("b_resp_clear", B_RESP, 0);
      B_READY = 1'b0;
   endtask

   task automatic apply_write(input int addr, input logic [63:0] data, input int lead, input bit aw_first);
      B_READY = 1'b1;
      if (lead == 0) begin
         AW_VALID = 1'b1; AW_ADDR = 17'(addr);
         W_VALID  = 1'b1; W_DATA  = data;
         #1;
         check_output("aw_ready_idle", AW_READY, 1);
         check_output("w_ready_idle", W_READY, 1);
         @(posedge clk); #1;
         AW_VALID = 1'b0; W_VALID = 1'b0;
      end else begin
         if (aw_first) begin AW_VALID = 1'b1; AW_ADDR = 17'(addr); end
         else begin W_VALID = 1'b1; W_DATA = data; end
         @(posedge clk); #1;
         AW_VALID = 1'b0; W_VALID = 1'b0;
         #1;
         check_output("missing_ready", aw_first ? W_READY : AW_READY, 1);
         check_output("captured_ready_drop", aw_first ? AW_READY : W_READY, 0);
         check_output("ar_ready_collect", AR_READY, 0);
         repeat (lead - 1) @(posedge clk);
         #1;
         if (aw_first) begin W_VALID = 1'b1; W_DATA = data; end
         else begin AW_VALID = 1'b1; AW_ADDR = 17'(addr); end
         @(posedge clk); #1;
         AW_VALID = 1'b0; W_VALID = 1'b0;
      end
      if (ref_ok(addr)) model_mem[ref_idx(addr)] = data;
      finish_write(addr);
   endtask

   task automatic apply_read(input int addr, input int hold);
      int cyc;
      logic [63:0] exp_data;
      logic [1:0]  exp_resp;
      exp_resp = ref_ok(addr) ? 2'b00 : 2'b10;
      exp_data = ref_ok(addr) ? model_mem[ref_idx(addr)] : 64'd0;
      R_READY  = (hold == 0);
      AR_VALID = 1'b1; AR_ADDR = 17'(addr);
      #1;
      check_output("ar_ready_idle", AR_READY, 1);
      @(posedge clk); #1;
      AR_VALID = 1'b0;
      cyc = 1;
      while (R_VALID !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_output("r_latency", 64'(cyc), 64'(RD_LAT));
      check_output("r_data", R_DATA, exp_data);
      check_output("r_resp", R_RESP, exp_resp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check_output("r_hold_valid", R_VALID, 1);
         check_output("r_hold_data", R_DATA, exp_data);
         check_output("r_hold_resp", R_RESP, exp_resp);
         check_output("r_hold_ar_ready", AR_READY, 0);
      end
      R_READY = 1'b1;
      @(posedge clk); #1;
      R_READY = 1'b0;
      check_output("r_valid_clear", R_VALID, 0);
      check_output("r_data_clear", R_DATA, 0);
      check_output("r_resp_clear", R_RESP, 0);
   endtask

   initial begin
      int cyc;
      int addr;
      int rec;
      logic [63:0] d;

      // reset values
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_output("rst_ar_ready", AR_READY, 1);
      check_output("rst_aw_ready", AW_READY, 1);
      check_output("rst_w_ready", W_READY, 1);
      check_output("rst_r_valid", R_VALID, 0);
      check_output("rst_b_valid", B_VALID, 0);
      check_output("rst_r_data", R_DATA, 0);
      check_output("rst_r_resp", R_RESP, 0);
      check_output("rst_b_resp", B_RESP, 0);

      // basic write then read of record 0
      apply_write(BASE, 64'h1234560C789ABC1F, 0, 1'b0);
      apply_read(BASE, 0);

      // W leads AW by three cycles into record 255
      apply_write(BASE + 'h7F8, 64'hFEDC_BA98_7654_3210, 3, 1'b0);
      apply_read(BASE + 'h7F8, 0);
      apply_write(BASE + 'h10, 64'h0F0F_1234_5678_9ABC, 2, 1'b1);
      apply_read(BASE + 'h10, 0);

      // error addresses
      apply_read(BASE + 4, 0);
      apply_read(BASE + 'h800, 0);
      apply_read(BASE - 8, 0);
      apply_write(BASE + 'h800, 64'hDEAD_BEEF_DEAD_BEEF, 0, 1'b0);
      apply_read(BASE, 0);

      // read held off by R_READY for five cycles
      apply_read(BASE + 'h7F8, 5);

      // read and write requested together: the read goes first
      d = 64'h0BAD_CAFE_1357_2468;
      R_READY  = 1'b1;
      B_READY  = 1'b1;
      AR_VALID = 1'b1; AR_ADDR = 17'(BASE);
      AW_VALID = 1'b1; AW_ADDR = 17'(BASE + 8);
      #1;
      check_output("race_ar_ready", AR_READY, 1);
      check_output("race_aw_ready", AW_READY, 0);
      check_output("race_w_ready", W_READY, 0);
      @(posedge clk); #1;
      AR_VALID = 1'b0;
      cyc = 1;
      while (R_VALID !== 1'b1 && cyc < 40) begin
         check_output("race_aw_blocked", AW_READY, 0);
         @(posedge clk); #1;
         cyc++;
      end
      check_output("race_r_latency", 64'(cyc), 64'(RD_LAT));
      check_output("race_r_data", R_DATA, model_mem[0]);
      @(posedge clk); #1;
      R_READY = 1'b0;
      check_output("race_r_done", R_VALID, 0);
      check_output("race_aw_accept", AW_READY, 1);
      W_VALID = 1'b1; W_DATA = d;
      @(posedge clk); #1;
      AW_VALID = 1'b0; W_VALID = 1'b0;
      model_mem[1] = d;
      finish_write(BASE + 8);
      apply_read(BASE + 8, 0);

      // reset in the middle of a write leaves the old record contents
      apply_write(BASE + 56, 64'hAAAA_AAAA_AAAA_AAAA, 0, 1'b0);
      B_READY  = 1'b1;
      AW_VALID = 1'b1; AW_ADDR = 17'(BASE + 56);
      W_VALID  = 1'b1; W_DATA  = 64'h5555_5555_5555_5555;
      @(posedge clk); #1;
      AW_VALID = 1'b0; W_VALID = 1'b0;
      rst_n = 1'b0;
      #1;
      check_output("mid_rst_ar_ready", AR_READY, 1);
      check_output("mid_rst_aw_ready", AW_READY, 1);
      check_output("mid_rst_w_ready", W_READY, 1);
      check_output("mid_rst_b_valid", B_VALID, 0);
      check_output("mid_rst_r_valid", R_VALID, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check_output("post_rst_no_b", B_VALID, 0);
      end
      B_READY = 1'b0;
      apply_read(BASE + 56, 0);

      // random traffic over records 0..15 plus error addresses
      for (int i = 0; i < 16; i++) begin
         apply_write(BASE + i * 8, {$urandom, $urandom}, 0, 1'b0);
      end
      for (int i = 0; i < 40; i++) begin
         rec = int'($urandom_range(15));
         if ($urandom_range(9) < 8) begin
            addr = BASE + rec * 8;
         end else begin
            case ($urandom_range(2))
               0:       addr = BASE + rec * 8 + int'($urandom_range(7, 1));
               1:       addr = BASE + 'h800 + 8 * int'($urandom_range(100));
               default: addr = BASE - 8 * int'($urandom_range(100, 1));
            endcase
         end
         if ($urandom_range(1) == 1) begin
            apply_write(addr, {$urandom, $urandom}, int'($urandom_range(4)), 1'($urandom_range(1)));
         end else begin
            apply_read(addr, int'($urandom_range(3)));
         end
      end
      for (int i = 0; i < 16; i++) begin
         apply_read(BASE + i * 8, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bev_dram_responder.md
Name: bev_dram_responder

Overview:
- Synthesizable AXI4-Lite slave that models the data-directory DRAM seen by the beverage program block.
- Holds 256 Data_Dir records, 64 bits each, and answers single-beat read and write transactions with configurable latency.
- Used on the bench and in FPGA bring-up in place of the behavioural pseudo-DRAM.
- Responder side of the program block's DRAM read/write initiator.

Parameters:
- BASE_ADDR, 17'h10000, byte address of record 0.
- RD_LAT, 2, cycles from AR handshake to R_VALID rising (1..15).
- WR_LAT, 2, cycles from capture of both AW and W to B_VALID rising (1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- AR_VALID  in  1  read address valid
- AR_ADDR  in  17  read byte address
- AR_READY  out  1  read address ready
- R_VALID  out  1  read data valid
- R_DATA  out  64  read data
- R_RESP  out  2  00 OKAY, 10 SLVERR
- R_READY  in  1  read data ready
- AW_VALID  in  1  write address valid
- AW_ADDR  in  17  write byte address
- AW_READY  out  1  write address ready
- W_VALID  in  1  write data valid
- W_DATA  in  64  write data
- W_READY  out  1  write data ready
- B_VALID  out  1  write response valid
- B_RESP  out  2  00 OKAY, 10 SLVERR
- B_READY  in  1  write response ready

Behaviour:
- Record layout, opaque to this block:
  - [63:52] Index_A, [51:40] Index_B, [39:32] Month (upper 4 bits 0), [31:20] Index_C, [19:8] Index_D, [7:0] Day (upper 3 bits 0).
  - Stored and returned bit-exact; no field checking.
- Address decode:
  - Valid iff addr[2:0]==0 and BASE_ADDR <= addr <= BASE_ADDR+0x7F8.
  - Record number = (addr-BASE_ADDR)>>3, 8 bits.
  - Any other address gives SLVERR: R_DATA=0 on reads; no memory change on writes.
- Memory: 256x64 array with no reset. Contents are undefined until written; the bench preloads through writes.
- Reset values: AR_READY=1, AW_READY=1, W_READY=1, R_VALID=0, B_VALID=0, R_DATA=0, R_RESP=0, B_RESP=0; FSM in IDLE; latency counter 0.
- Reset mid-transaction aborts it. No response is issued. A write whose commit cycle has not yet occurred leaves memory unchanged.
- One transaction outstanding at a time. FSM states: IDLE, RD_WAIT, RD_RESP, WR_COLLECT, WR_WAIT, WR_RESP.
- IDLE:
  - AR_READY=AW_READY=W_READY=1.
  - AR_VALID with no AW_VALID/W_VALID: capture AR_ADDR, go to RD_WAIT.
  - AR_VALID together with AW_VALID or W_VALID: read wins. AW_READY and W_READY are 0 in that cycle; the write handshake does not occur.
  - AW_VALID and W_VALID both high with no AR_VALID: capture both, go to WR_WAIT.
  - Only one of AW_VALID/W_VALID high with no AR_VALID: capture it, go to WR_COLLECT.
- RD_WAIT:
  - All READY signals 0.
  - Count RD_LAT-1 cycles, then register R_DATA/R_RESP and raise R_VALID. With RD_LAT=1, R_VALID is high the cycle after the AR handshake.
- RD_RESP:
  - R_VALID, R_DATA and R_RESP hold stable until R_VALID&&R_READY.
  - On that handshake: next cycle R_VALID=0, R_DATA=0, R_RESP=0, and the FSM returns to IDLE.
- WR_COLLECT:
  - AR_READY=0. Only the READY of the missing channel is high.
  - When the missing channel arrives, go to WR_WAIT.
- WR_WAIT:
  - All READY signals 0.
  - After WR_LAT cycles, commit the write (if the address is valid) and raise B_VALID with B_RESP in the same cycle.
- WR_RESP:
  - B_VALID and B_RESP hold until B_READY.
  - Then B_VALID=0, B_RESP=0, and the FSM returns to IDLE.
- Coherency: a read whose AR handshake follows a completed B handshake returns the new data.
- Back-to-back: the earliest next address accept is the cycle after R or B deasserts.

Test Plan:
- Write 64'h123_456_0C_789_ABC_1F to 0x10000 with AW and W in the same cycle, B_READY=1 -> with WR_LAT=2, B_VALID high 2 cycles after capture, B_RESP=00. Read 0x10000 -> R_DATA=64'h1234560C789ABC1F, R_RESP=00, R_VALID high RD_LAT=2 cycles after the AR handshake.
- W_VALID 3 cycles before AW_VALID, address 0x107F8 (record 255) -> W_READY drops after capture, AW accepted later, write committed. Read-back of 0x107F8 matches.
- Read 0x10004 (misaligned) and read 0x10800 (out of range) -> R_RESP=10, R_DATA=0. A write to 0x10800 returns B_RESP=10 and record 0 is unchanged.
- AR_VALID and AW_VALID asserted in the same IDLE cycle -> AR_READY=1, AW_READY=0. The read completes first; the write is accepted only after the R handshake.
- Hold R_READY=0 for 5 cycles -> R_VALID, R_DATA and R_RESP stay stable all 5 cycles; AR_READY=0 throughout.
- Assert rst_n=0 during WR_WAIT of a write to record 7 holding 64'hAAAA... -> all outputs return to reset values asynchronously, no B response, record 7 still reads 64'hAAAA....
